// File: rtl/cmp_result_blinker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cmp_result_blinker                                              |
// | Purpose  : Plays one {eq,gt,lt} comparator result as an LED blink code     |
// |            (eq=1, gt=2, lt=3, malformed=4 blinks with sticky err).         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module cmp_result_blinker #(
  parameter int TICK_DIV  = 12000000,
  parameter int ON_TICKS  = 1,
  parameter int OFF_TICKS = 1,
  parameter int GAP_TICKS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic eq,
  input  logic gt,
  input  logic lt,
  input  logic in_valid,
  output logic in_ready,
  output logic led,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int c_PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_PHASE_MAX_A = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int c_PHASE_MAX = (c_PHASE_MAX_A > GAP_TICKS) ? c_PHASE_MAX_A : GAP_TICKS;
  localparam int c_PHASE_W = (c_PHASE_MAX > 1) ? $clog2(c_PHASE_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_OFF  = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [c_PRESC_W-1:0]   r_presc;
  logic [c_PHASE_W-1:0]   r_phase;
  logic [2:0]             r_remain;
  logic                   r_led;
  logic                   r_done;
  logic                   r_err;

  logic                   w_tick;
  logic [c_PHASE_W-1:0]   w_limit;
  logic                   w_phase_end;

  assign w_tick = (r_presc == c_PRESC_W'(TICK_DIV - 1));

  // Last tick index of whichever phase is currently running.
  always_comb begin
    w_limit = '0;
    case (r_state)
      S_ON:    w_limit = c_PHASE_W'(ON_TICKS - 1);
      S_OFF:   w_limit = c_PHASE_W'(OFF_TICKS - 1);
      S_GAP:   w_limit = c_PHASE_W'(GAP_TICKS - 1);
      default: w_limit = '0;
    endcase
  end

  assign w_phase_end = w_tick && (r_phase == w_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_phase  <= '0;
      r_remain <= '0;
      r_led    <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE) begin
        r_presc <= w_tick ? '0 : r_presc + c_PRESC_W'(1);
        if (w_tick) begin
          r_phase <= w_phase_end ? '0 : r_phase + c_PHASE_W'(1);
        end
      end
      case (r_state)
        S_IDLE: begin
          r_led <= 1'b0;
          if (in_valid) begin
            r_state <= S_ON;
            r_led   <= 1'b1;
            r_presc <= '0;
            r_phase <= '0;
            case ({eq, gt, lt})
              3'b100:  begin r_remain <= 3'd1; r_err <= 1'b0; end
              3'b010:  begin r_remain <= 3'd2; r_err <= 1'b0; end
              3'b001:  begin r_remain <= 3'd3; r_err <= 1'b0; end
              default: begin r_remain <= 3'd4; r_err <= 1'b1; end
            endcase
          end
        end
        S_ON: begin
          if (w_phase_end) begin
            r_led   <= 1'b0;
            r_state <= (r_remain > 3'd1) ? S_OFF : S_GAP;
          end
        end
        S_OFF: begin
          if (w_phase_end) begin
            r_led    <= 1'b1;
            r_state  <= S_ON;
            r_remain <= r_remain - 3'd1;
          end
        end
        S_GAP: begin
          if (w_phase_end) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_led   <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign in_ready = !busy;
  assign led      = r_led;
  assign done     = r_done;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cmp_result_blinker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_cmp_result_blinker                                           |
// | Purpose  : Directed self-checking bench for cmp_result_blinker.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_cmp_result_blinker;

  localparam int c_ON_CYC  = 8;
  localparam int c_OFF_CYC = 4;
  localparam int c_GAP_CYC = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic eq = 1'b0, gt = 1'b0, lt = 1'b0, in_valid = 1'b0;
  logic in_ready, led, busy, done, err;

  int vectors = 0;
  int miscompares = 0;

  cmp_result_blinker #(
    .TICK_DIV (4),
    .ON_TICKS (2),
    .OFF_TICKS(1),
    .GAP_TICKS(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .eq      (eq),
    .gt      (gt),
    .lt      (lt),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .led     (led),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic exp_led(input int n, input int i);
    int p = i - 1;
    if (p >= n * (c_ON_CYC + c_OFF_CYC) - c_OFF_CYC) return 1'b0;
    return ((p % (c_ON_CYC + c_OFF_CYC)) < c_ON_CYC);
  endfunction

  // Called at a negedge; accept happens at the following posedge.
  // hold != 0 keeps in_valid high with gt=1 for the whole busy window.
  task automatic play(input logic [2:0] flags, input int n, input logic exp_err,
                      input bit hold, input string tag);
    int total = n * c_ON_CYC + (n - 1) * c_OFF_CYC + c_GAP_CYC;
    int led_bad = 0;
    int busy_bad = 0;
    {eq, gt, lt} = flags;
    in_valid = 1'b1;
    for (int i = 1; i <= total; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (hold) {eq, gt, lt} = 3'b010;
        else in_valid = 1'b0;
        check({tag, "_err"}, err, exp_err);
        check({tag, "_ready_busy"}, in_ready, 1'b0);
      end
      if (led !== exp_led(n, i)) led_bad++;
      if (busy !== 1'b1 || done !== 1'b0) busy_bad++;
    end
    vectors++;
    assert (led_bad == 0) else begin
      miscompares++;
      $error("FAIL %s_led_pattern: observed %0d bad cycles expected 0", tag, led_bad);
    end
    vectors++;
    assert (busy_bad == 0) else begin
      miscompares++;
      $error("FAIL %s_busy_window: observed %0d bad cycles expected 0", tag, busy_bad);
    end
    @(negedge clk);
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_idle_busy"}, busy, 1'b0);
    check({tag, "_idle_ready"}, in_ready, 1'b1);
    check({tag, "_idle_led"}, led, 1'b0);
    check({tag, "_err_hold"}, err, exp_err);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_done_clear"}, done, 1'b0);
    check({tag, "_stay_idle"}, busy, 1'b0);
  endtask

  initial begin
    // Reset asserted with a valid eq result presented: nothing accepted.
    eq = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_led", led, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    rst = 1'b0;
    in_valid = 1'b0;
    eq = 1'b0;
    idle_check("post_rst");

    play(3'b100, 1, 1'b0, 1'b0, "eq");
    idle_check("eq");
    play(3'b010, 2, 1'b0, 1'b0, "gt");
    idle_check("gt");

    // lt with gt held valid during busy: second code taken on the done cycle.
    play(3'b001, 3, 1'b0, 1'b1, "lt_hold");
    play(3'b010, 2, 1'b0, 1'b0, "gt_after_hold");
    idle_check("gt_after_hold");

    play(3'b110, 4, 1'b1, 1'b0, "bad110");
    idle_check("bad110");
    play(3'b000, 4, 1'b1, 1'b0, "bad000");
    play(3'b100, 1, 1'b0, 1'b0, "eq_clear");
    idle_check("eq_clear");

    // lt code interrupted by reset in the middle of its first OFF phase.
    play_partial();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_led", led, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    idle_check("mid_rst");
    play(3'b100, 1, 1'b0, 1'b0, "eq_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Starts an lt code and stops at cycle 10 (inside the first OFF phase).
  task automatic play_partial();
    {eq, gt, lt} = 3'b001;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("lt_partial_off_led", led, 1'b0);
    check("lt_partial_busy", busy, 1'b1);
  endtask

endmodule
`default_nettype wire
